// File: rtl/pipe_pkg.sv
// Shared constants for the parametrised pipeline backbone.
// Holds default geometry, reset values and the stall-vector width.
package pipe_pkg;

  localparam int unsigned STAGES_DEF  = 5;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned CNT_W_DEF   = 16;

  // Stall vector carries one bit per stage.
  localparam int unsigned STALL_W_DEF = STAGES_DEF;

  // Reset contents of a stage register.
  localparam logic                  RST_VALID = 1'b0;
  localparam logic [DATA_W_DEF-1:0] RST_DATA  = '0;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register (valid bit + payload).
// Ports:
//   clk, rst       clock, synchronous active-low reset
//   flush          invalidate content at the next edge (data held)
//   hold           keep current valid and data
//   bubble         load an empty slot (valid=0, data held)
//   up_valid/data  upstream content loaded when none of the above apply
//   data_en        payload load enable for the upstream load
//   valid, data    registered stage content
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              bubble,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  input  logic              data_en,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Priority: reset, flush, hold, bubble, load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= RST_VALID;
      data  <= DATA_W'(RST_DATA);
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!hold) begin
      if (bubble) begin
        valid <= 1'b0;
      end else begin
        valid <= up_valid;
        if (data_en) begin
          data <= up_data;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Parametrised pipeline backbone: STAGES payload registers with valid bits,
// stall propagation toward upstream, bubble insertion and global flush.
// Ports:
//   clk, rst             clock, synchronous active-low reset
//   in_valid, in_data    new payload for stage 0
//   in_ready             combinational accept indication
//   stall_req            per-stage stall request (ignored on empty stages)
//   flush                invalidate all stages at the next edge
//   stg_valid, stg_data  registered stage contents, stage k at [k*DATA_W +: DATA_W]
//   stall_o              combinational stall vector
//   out_valid, out_data  last-stage content leaving the pipe
//   stall_cnt            saturating count of cycles with stage 0 stalled
module pipe_stage_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned STAGES = STAGES_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_ready,
  input  logic [STAGES-1:0]        stall_req,
  input  logic                     flush,
  output logic [STAGES-1:0]        stg_valid,
  output logic [STAGES*DATA_W-1:0] stg_data,
  output logic [STAGES-1:0]        stall_o,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int unsigned STALL_W = STAGES;

  logic [STALL_W-1:0] req;
  logic [STAGES-1:0]  up_valid;
  logic [STAGES-1:0]  bubble;
  logic [STAGES-1:0]  data_en;
  logic [DATA_W-1:0]  up_data [STAGES];

  // Requests from empty stages are ignored.
  assign req = stall_req & stg_valid;

  // Suffix OR: a stall blocks every stage upstream of the requester.
  always_comb begin
    logic acc;
    acc     = 1'b0;
    stall_o = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      acc        = acc | req[k];
      stall_o[k] = acc;
    end
  end

  // Upstream source of each stage; stage 0 only captures data with in_valid.
  always_comb begin
    up_valid    = '0;
    bubble      = '0;
    data_en     = '0;
    up_valid[0] = in_valid;
    up_data[0]  = in_data;
    data_en[0]  = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      up_valid[k] = stg_valid[k-1];
      up_data[k]  = stg_data[(k-1)*DATA_W +: DATA_W];
      bubble[k]   = stall_o[k-1];
      data_en[k]  = 1'b1;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    pipe_stage_reg #(
      .DATA_W (DATA_W)
    ) u_reg (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .hold     (stall_o[g]),
      .bubble   (bubble[g]),
      .up_valid (up_valid[g]),
      .up_data  (up_data[g]),
      .data_en  (data_en[g]),
      .valid    (stg_valid[g]),
      .data     (stg_data[g*DATA_W +: DATA_W])
    );
  end

  // Saturating stall-cycle counter; flush cycles are not counted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_o[0] && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = ~stall_o[0] & ~flush;
  assign out_valid = stg_valid[STAGES-1] & ~stall_o[STAGES-1];
  assign out_data  = stg_data[(STAGES-1)*DATA_W +: DATA_W];

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl: directed scenarios plus random
// traffic against a behavioural stage model and an in-order scoreboard.
module tb_pipe_stage_ctrl;

  localparam int unsigned S  = 5;
  localparam int unsigned DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [DW-1:0]   in_data;
  logic [S-1:0]    stall_req;
  logic            flush;

  logic            in_ready,  in_ready4;
  logic [S-1:0]    stg_valid, stg_valid4;
  logic [S*DW-1:0] stg_data,  stg_data4;
  logic [S-1:0]    stall_o,   stall_o4;
  logic            out_valid, out_valid4;
  logic [DW-1:0]   out_data,  out_data4;
  logic [15:0]     stall_cnt;
  logic [3:0]      stall_cnt4;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit          m_valid [S];
  logic [31:0] m_data  [S];
  int          m_cnt;
  int          m_cnt4;
  logic [31:0] sbq [$];

  always #5 clk = ~clk;

  pipe_stage_ctrl #(.STAGES(S), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .stall_req(stall_req), .flush(flush),
    .stg_valid(stg_valid), .stg_data(stg_data), .stall_o(stall_o),
    .out_valid(out_valid), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_ctrl #(.STAGES(S), .DATA_W(DW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready4), .stall_req(stall_req), .flush(flush),
    .stg_valid(stg_valid4), .stg_data(stg_data4), .stall_o(stall_o4),
    .out_valid(out_valid4), .out_data(out_data4), .stall_cnt(stall_cnt4)
  );

  // Stage k is stalled when any occupied stage at or after k requests a stall.
  function automatic bit m_stall(int k);
    for (int j = k; j < int'(S); j++)
      if (stall_req[j] && m_valid[j]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [S-1:0] m_stall_vec();
    logic [S-1:0] v;
    for (int k = 0; k < int'(S); k++) v[k] = m_stall(k);
    return v;
  endfunction

  function automatic logic [S-1:0] m_valid_vec();
    logic [S-1:0] v;
    for (int k = 0; k < int'(S); k++) v[k] = m_valid[k];
    return v;
  endfunction

  function automatic logic [S*DW-1:0] m_data_vec();
    logic [S*DW-1:0] v;
    for (int k = 0; k < int'(S); k++) v[k*DW +: DW] = m_data[k];
    return v;
  endfunction

  // Advance the model with the current inputs, then cross one clock edge.
  task automatic tick();
    bit          nv [S];
    logic [31:0] nd [S];
    bit          st [S];
    bit          acc, pop;
    for (int k = 0; k < int'(S); k++) begin
      st[k] = m_stall(k);
      nv[k] = m_valid[k];
      nd[k] = m_data[k];
    end
    acc = in_valid && !st[0] && !flush;
    pop = m_valid[S-1] && !st[S-1];
    if (!rst) begin
      for (int k = 0; k < int'(S); k++) begin nv[k] = 1'b0; nd[k] = '0; end
      m_cnt = 0; m_cnt4 = 0;
      sbq.delete();
    end else begin
      for (int k = 0; k < int'(S); k++) begin
        if (flush)                 nv[k] = 1'b0;
        else if (st[k])            ;
        else if (k > 0 && st[k-1]) nv[k] = 1'b0;
        else if (k > 0)            begin nv[k] = m_valid[k-1]; nd[k] = m_data[k-1]; end
        else                       begin nv[k] = in_valid; if (in_valid) nd[k] = in_data; end
      end
      if (st[0] && !flush) begin
        if (m_cnt  < 65535) m_cnt++;
        if (m_cnt4 < 15)    m_cnt4++;
      end
      if (flush) sbq.delete();
      else begin
        if (pop && sbq.size() > 0) void'(sbq.pop_front());
        if (acc) sbq.push_back(in_data);
      end
    end
    @(posedge clk);
    for (int k = 0; k < int'(S); k++) begin m_valid[k] = nv[k]; m_data[k] = nd[k]; end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'($urandom); in_data = $urandom; stall_req = S'($urandom);
      flush = 1'($urandom);
      tick();
    end
    flush = 1'b0; in_valid = 1'($urandom); stall_req = S'($urandom);
    #1;
    checks++; if (stg_valid !== 5'b00000) begin failures++; $display("FAIL reset_valid got=%b exp=00000", stg_valid); end
    checks++; if (stg_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", stg_data); end
    checks++; if (stall_o !== 5'b00000) begin failures++; $display("FAIL reset_stall got=%b exp=00000", stall_o); end
    checks++; if (stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%h/%h exp=0", stall_cnt, stall_cnt4); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    rst = 1'b1; in_valid = 1'b0; stall_req = '0;
  endtask

  task automatic test_stream();
    stall_req = '0; flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h10 + 32'(i);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready i=%0d got=%b exp=1", i, in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_early_out i=%0d got=%b exp=0", i, out_valid); end
      tick();
    end
    in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h10 + 32'(j)) begin
        failures++; $display("FAIL stream_out j=%0d got=%b/%h exp=1/%h", j, out_valid, out_data, 32'h10 + 32'(j));
      end
      tick();
    end
  endtask

  task automatic test_stall();
    logic [31:0] got [$];
    int cb, cb4;
    stall_req = '0; flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h10 + 32'(i);
      #1; if (out_valid) got.push_back(out_data);
      tick();
    end
    cb = m_cnt; cb4 = m_cnt4;
    stall_req = 5'b00100; in_valid = 1'b1; in_data = 32'h15;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (stall_o !== 5'b00111 || in_ready !== 1'b0) begin
        failures++; $display("FAIL stall_vec c=%0d got=%b/%b exp=00111/0", c, stall_o, in_ready);
      end
      if (out_valid) got.push_back(out_data);
      tick();
      if (c == 0) begin
        checks++; if (stg_valid[3] !== 1'b0 || stg_valid[2] !== 1'b1 || stg_data[2*DW +: DW] !== 32'h12) begin
          failures++; $display("FAIL stall_bubble got=%b/%h exp=v3=0 v2=1 d2=12", stg_valid, stg_data[2*DW +: DW]);
        end
      end
    end
    checks++; if (stall_cnt !== 16'(cb + 3) || stall_cnt4 !== 4'(cb4 + 3)) begin
      failures++; $display("FAIL stall_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, stall_cnt4, cb + 3, cb4 + 3);
    end
    stall_req = '0;
    #1; if (out_valid) got.push_back(out_data);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1; if (out_valid) got.push_back(out_data);
      tick();
    end
    checks++; if (got.size() != 6) begin failures++; $display("FAIL stall_count_out got=%0d exp=6", got.size()); end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      checks++; if (got[i] !== 32'h10 + 32'(i)) begin
        failures++; $display("FAIL stall_order i=%0d got=%h exp=%h", i, got[i], 32'h10 + 32'(i));
      end
    end
  endtask

  task automatic test_bubble_req();
    logic [S-1:0] one;
    stall_req = 5'b01000; flush = 1'b0; in_valid = 1'b1; in_data = 32'h20;
    #1;
    checks++; if (stall_o !== 5'b00000 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bubble_req got=%b/%b exp=00000/1", stall_o, in_ready);
    end
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      one = 5'b00001 << c;
      checks++; if (stall_o !== 5'b00000 || in_ready !== 1'b1 || stg_valid !== one) begin
        failures++; $display("FAIL bubble_flow c=%0d got=%b/%b/%b exp=00000/1/%b", c, stall_o, in_ready, stg_valid, one);
      end
      tick();
    end
    stall_req = '0;
    #1;
    checks++; if (stg_valid !== 5'b01000) begin failures++; $display("FAIL bubble_s3 got=%b exp=01000", stg_valid); end
    tick();
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h20) begin
      failures++; $display("FAIL bubble_out got=%b/%h exp=1/20", out_valid, out_data);
    end
    tick();
  endtask

  task automatic test_flush();
    int cb;
    stall_req = '0; flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'h30 + 32'(i);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h35; stall_req = 5'b10000;
    #1;
    checks++; if (in_ready !== 1'b0 || stall_o !== 5'b11111) begin
      failures++; $display("FAIL flush_in_ready got=%b/%b exp=0/11111", in_ready, stall_o);
    end
    cb = m_cnt;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (stg_valid !== 5'b00000 || stall_o !== 5'b00000 || in_ready !== 1'b1) begin
      failures++; $display("FAIL flush_clear got=%b/%b/%b exp=00000/00000/1", stg_valid, stall_o, in_ready);
    end
    checks++; if (stall_cnt !== 16'(cb)) begin failures++; $display("FAIL flush_cnt got=%0d exp=%0d", stall_cnt, cb); end
    stall_req = '0;
    for (int c = 0; c < 6; c++) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop c=%0d got=%b/%h exp=0", c, out_valid, out_data); end
      tick();
    end
  endtask

  task automatic test_saturate();
    stall_req = '0; flush = 1'b0; in_valid = 1'b1; in_data = 32'h40;
    tick();
    in_valid = 1'b0; stall_req = 5'b00001;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++; if (stall_cnt4 !== 4'(m_cnt4)) begin
        failures++; $display("FAIL sat_step c=%0d got=%0d exp=%0d", c, stall_cnt4, m_cnt4);
      end
    end
    checks++; if (stall_cnt4 !== 4'hF) begin failures++; $display("FAIL sat_max got=%h exp=f", stall_cnt4); end
    checks++; if (stall_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL sat_wide got=%0d exp=%0d", stall_cnt, m_cnt); end
    rst = 1'b0;
    tick();
    rst = 1'b1; stall_req = '0;
    checks++; if (stall_cnt4 !== 4'h0 || stall_cnt !== 16'h0 || stg_valid !== '0 || stg_valid4 !== '0) begin
      failures++; $display("FAIL sat_reset got=%h/%h/%b/%b exp=0/0/0/0", stall_cnt4, stall_cnt, stg_valid, stg_valid4);
    end
  endtask

  task automatic test_random();
    bit ev;
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 63) != 0);
      flush    = ($urandom_range(0, 31) == 0);
      in_valid = 1'($urandom);
      in_data  = $urandom;
      for (int k = 0; k < int'(S); k++) stall_req[k] = ($urandom_range(0, 5) == 0);
      #1;
      checks++; if (stall_o !== m_stall_vec() || stall_o4 !== m_stall_vec()) begin
        failures++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall_o, m_stall_vec());
      end
      checks++; if (in_ready !== (!m_stall(0) && !flush)) begin
        failures++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, in_ready, !m_stall(0) && !flush);
      end
      ev = m_valid[S-1] && !m_stall(S-1);
      checks++; if (out_valid !== ev) begin
        failures++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, out_valid, ev);
      end
      if (ev) begin
        checks++; if (sbq.size() == 0 || out_data !== sbq[0]) begin
          failures++; $display("FAIL rnd_order c=%0d got=%h exp=%h q=%0d", c, out_data, (sbq.size() > 0) ? sbq[0] : 32'hx, sbq.size());
        end
      end
      tick();
      checks++; if (stg_valid !== m_valid_vec() || stg_data !== m_data_vec()) begin
        failures++; $display("FAIL rnd_state c=%0d got=%b/%h exp=%b/%h", c, stg_valid, stg_data, m_valid_vec(), m_data_vec());
      end
      checks++; if (stall_cnt !== 16'(m_cnt) || stall_cnt4 !== 4'(m_cnt4)) begin
        failures++; $display("FAIL rnd_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, stall_cnt, stall_cnt4, m_cnt, m_cnt4);
      end
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; stall_req = '0; flush = 1'b0;
    m_cnt = 0; m_cnt4 = 0;
    for (int k = 0; k < int'(S); k++) begin m_valid[k] = 1'b0; m_data[k] = '0; end
    test_reset();
    test_stream();
    test_stall();
    test_bubble_req();
    test_flush();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_ctrl.md
Name: pipe_stage_ctrl

Overview:
Parametrised pipeline backbone that generalises the fixed five-stage register chain of the CPU core. Holds STAGES payload registers with per-stage valid bits and builds the stall vector from per-stage stall requests. Inserts bubbles at stall boundaries and supports a global flush. Replaces hand-instantiated inter-stage latches (if_id, id_ex, ex_mem, mem_wb style) and adds stall/flush behaviour those latches lack.

Parameters:
STAGES, 5, number of pipeline stage registers (>= 2)
DATA_W, 32, payload width per stage
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-low reset
in_valid  in  1  new payload presented to stage 0
in_data  in  DATA_W  payload for stage 0
in_ready  out  1  combinational; = ~stall_o[0] & ~flush
stall_req  in  STAGES  bit k: stage k's content cannot advance this cycle
flush  in  1  invalidate all stages at the next edge
stg_valid  out  STAGES  registered valid bit of each stage
stg_data  out  STAGES*DATA_W  registered payload; stage k at bits [k*DATA_W +: DATA_W]
stall_o  out  STAGES  combinational stall vector
out_valid  out  1  = stg_valid[STAGES-1] & ~stall_o[STAGES-1]
out_data  out  DATA_W  = payload of stage STAGES-1
stall_cnt  out  CNT_W  cycles with stall_o[0]=1, saturating

Behaviour:
- Reset (rst=0 at an edge): all stg_valid=0, all stg_data=0, stall_cnt=0. The combinational outputs then read stall_o=0, in_ready=1 (flush=0), out_valid=0. Reset overrides flush and stall.
- Effective request: req[k] = stall_req[k] & stg_valid[k]. A request from an empty stage (bubble) is ignored.
- stall_o[k] = OR of req[j] for j >= k. A stall propagates to all upstream stages.
- Per-stage update at each edge, k > 0, in priority order:
  1. flush: valid=0, data held.
  2. stall_o[k]: hold valid and data.
  3. stall_o[k-1] (stage k-1 is stalled, stage k is not): load bubble, valid=0, data held.
  4. Otherwise: load valid and data from stage k-1.
- Stage 0 update at each edge:
  1. flush: valid=0.
  2. stall_o[0]: hold.
  3. Otherwise: valid <= in_valid, data <= in_data when in_valid=1.
- Acceptance: an input is accepted only when in_valid & in_ready. With flush=1 the input is dropped.
- Latency: an input accepted at edge t is in stage k after edge t+k. With no stalls, out_valid is high during the cycle after edge t+STAGES-1, i.e. STAGES cycles after acceptance.
- Exit: the last stage's content leaves the pipe at any edge where stall_o[STAGES-1]=0.
- Stall counter: stall_cnt increments at each edge where stall_o[0]=1 and flush=0. It saturates at all-ones and never wraps.
- flush combined with active stall_req: flush wins. After the edge all valid=0, so stall_o falls to 0 in the next cycle.
- Reset mid-stall or mid-flush: same result as a plain reset.
- Ordering guarantee: no payload is duplicated or reordered. Payloads are lost only on flush or reset.

Decomposition:
- Shared package pipe_pkg:
  - default STAGES, DATA_W and CNT_W constants.
  - reset-value constants (zero payload, zero valid).
  - localparam for the stall-vector width.
- Sub-module pipe_stage_reg: one stage register with inputs for flush, hold and bubble, plus upstream valid/data. Generated STAGES times.
- The stall-vector prefix-OR and the counter live in the top.

Test Plan:
Defaults STAGES=5, DATA_W=32, CNT_W=16 unless stated.
1. rst=0 for 2 cycles with random inputs -> stg_valid=5'b00000, stg_data=0, stall_o=0, stall_cnt=0, in_ready=1, out_valid=0.
2. Push 0x10..0x14 on 5 consecutive cycles, no stalls -> out_valid first high 5 cycles after 0x10 is accepted, out_data=0x10; 0x11..0x14 follow on consecutive cycles.
3. Stage 2 holds 0x12 (valid); stall_req[2]=1 for 3 cycles ->
   - stall_o=5'b00111 and in_ready=0 for those cycles.
   - stage 3 gets a bubble at the first stall edge; stages 0-2 hold.
   - stall_cnt +3.
   - after release, sequence continues 0x12, 0x13, ... with no loss or duplicate.
4. stall_req[3]=1 while stg_valid[3]=0 -> stall_o=0, in_ready=1, flow unaffected.
5. Full pipe; flush=1 with in_valid=1 and stall_req[4]=1 -> in_ready=0, input dropped; next cycle stg_valid=0, stall_o=0, stall_cnt unchanged.
6. CNT_W=4; hold stall_req[0]=1 with stage 0 valid for 20 cycles -> stall_cnt stops at 0xF; rst=0 one cycle -> stall_cnt=0, stg_valid=0.
